// File: rtl/wb_pkg.sv
// Shared widths, memory-size encodings and write-back queue entry layout for wb_stage.
// Width macros ASIZE/DSIZE/NREG default here when not already provided by define.v.
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef DSIZE
`define DSIZE 32
`endif
`ifndef NREG
`define NREG 32
`endif

package wb_pkg;

    localparam int unsigned AW = `ASIZE;
    localparam int unsigned DW = `DSIZE;

    localparam logic [1:0] MSZ_BYTE = 2'b00;
    localparam logic [1:0] MSZ_HALF = 2'b01;
    localparam logic [1:0] MSZ_WORD = 2'b10;

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Combinational load-data extension: byte/half sign- or zero-extended, word passed through.
module load_ext
    import wb_pkg::*;
(
    input  logic [DW-1:0] data,
    input  logic [1:0]    size,
    input  logic          sign_ext,
    output logic [DW-1:0] result_c
);

    always_comb begin
        result_c = data;
        case (size)
            MSZ_BYTE: result_c = {{(DW-8){sign_ext & data[7]}}, data[7:0]};
            MSZ_HALF: result_c = {{(DW-16){sign_ext & data[15]}}, data[15:0]};
            MSZ_WORD: result_c = data;
            default:  result_c = data;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: in-order queue of selected/extended results draining into the register file.
// Optional macro WB_FWD_EN builds bypass lookup of queued results for the decode read ports.
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_wen,
    input  logic [AW-1:0] in_waddr,
    input  logic          in_sel,
    input  logic [DW-1:0] in_alu_data,
    input  logic [DW-1:0] in_mem_data,
    input  logic [1:0]    in_mem_size,
    input  logic          in_mem_signed,
    input  logic          hold,
    output logic          rf_wen,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic [AW-1:0] fwd_addr1,
    input  logic [AW-1:0] fwd_addr2,
    output logic          fwd_hit1,
    output logic          fwd_hit2,
    output logic [DW-1:0] fwd_data1,
    output logic [DW-1:0] fwd_data2,
    output logic [31:0]   retire_cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    wb_entry_t     q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [DW-1:0] ext_data;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    wb_entry_t     head_e;
    wb_entry_t     in_e;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    load_ext u_load_ext (
        .data     (in_mem_data),
        .size     (in_mem_size),
        .sign_ext (in_mem_signed),
        .result_c (ext_data)
    );

    // Reset suppresses both ends so queued entries are discarded, never written.
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop      = !empty && !hold && !rst;
    assign in_ready = !full || pop;
    assign push     = in_valid && in_ready && !rst;

    assign head_e = q[head];
    assign in_e   = '{wen: in_wen, waddr: in_waddr, data: (in_sel ? ext_data : in_alu_data)};

    assign rf_wen   = pop && head_e.wen && (head_e.waddr != '0);
    assign rf_waddr = empty ? '0 : head_e.waddr;
    assign rf_wdata = empty ? '0 : head_e.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            retire_cnt <= '0;
        end else begin
            if (push) begin
                q[tail] <= in_e;
                tail    <= ptr_inc(tail);
            end
            if (pop) begin
                head       <= ptr_inc(head);
                retire_cnt <= retire_cnt + 32'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef WB_FWD_EN
    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        idx       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = PW'((32'(head) + i) % DEPTH);
            if ((CW'(i) < count) && q[idx].wen && (q[idx].waddr != '0)) begin
                if (q[idx].waddr == fwd_addr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = q[idx].data;
                end
                if (q[idx].waddr == fwd_addr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = q[idx].data;
                end
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_addr1, fwd_addr2};
    assign fwd_hit1   = 1'b0;
    assign fwd_hit2   = 1'b0;
    assign fwd_data1  = '0;
    assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_stage;
    import wb_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_wen;
    logic [AW-1:0] in_waddr;
    logic          in_sel;
    logic [DW-1:0] in_alu_data;
    logic [DW-1:0] in_mem_data;
    logic [1:0]    in_mem_size;
    logic          in_mem_signed;
    logic          hold;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] fwd_addr1;
    logic [AW-1:0] fwd_addr2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
    logic [31:0]   retire_cnt;

    wb_stage #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wen        (in_wen),
        .in_waddr      (in_waddr),
        .in_sel        (in_sel),
        .in_alu_data   (in_alu_data),
        .in_mem_data   (in_mem_data),
        .in_mem_size   (in_mem_size),
        .in_mem_signed (in_mem_signed),
        .hold          (hold),
        .rf_wen        (rf_wen),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .fwd_addr1     (fwd_addr1),
        .fwd_addr2     (fwd_addr2),
        .fwd_hit1      (fwd_hit1),
        .fwd_hit2      (fwd_hit2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2),
        .retire_cnt    (retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wen;
        int unsigned addr;
        int unsigned data;
    } ment_t;

    ment_t       mq[$];
    int unsigned m_rcnt = 0;
    int          checks = 0;
    int          failures = 0;
`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned ext_model(bit sel, int unsigned alu, int unsigned mem,
                                              int unsigned sz, bit sgn);
        int unsigned v;
        if (!sel) return alu;
        if (sz == 0) begin
            v = mem % 256;
            if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = mem % 65536;
            if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = mem;
        end
        return v;
    endfunction

    task automatic set_in(input bit v, input bit wen, input int unsigned addr, input bit sel,
                          input int unsigned alu, input int unsigned mem, input int unsigned sz,
                          input bit sgn, input bit hd);
        in_valid      = v;
        in_wen        = wen;
        in_waddr      = AW'(addr);
        in_sel        = sel;
        in_alu_data   = DW'(alu);
        in_mem_data   = DW'(mem);
        in_mem_size   = 2'(sz);
        in_mem_signed = sgn;
        hold          = hd;
    endtask

    task automatic set_idle(input bit hd);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, hd);
    endtask

    // Compare every output against the model, then advance the model across one clock edge.
    task automatic tick();
        bit          e_pop, e_ready, e_push, r, h1, h2;
        int unsigned d1, d2;
        ment_t       hd, ne;
        #1;
        e_pop   = (mq.size() != 0) && !hold && !rst;
        e_ready = (mq.size() < DEPTH) || e_pop;
        hd      = '{wen: 0, addr: 0, data: 0};
        if (mq.size() != 0) hd = mq[0];
        h1 = 0; h2 = 0; d1 = 0; d2 = 0;
        if (FWD) begin
            foreach (mq[i]) begin
                if (mq[i].wen && mq[i].addr != 0 && mq[i].addr == 32'(fwd_addr1)) begin
                    h1 = 1; d1 = mq[i].data;
                end
                if (mq[i].wen && mq[i].addr != 0 && mq[i].addr == 32'(fwd_addr2)) begin
                    h2 = 1; d2 = mq[i].data;
                end
            end
        end
        check_eq("in_ready", 32'(in_ready), 32'(e_ready));
        check_eq("rf_wen", 32'(rf_wen), 32'(e_pop && hd.wen && hd.addr != 0));
        check_eq("rf_waddr", 32'(rf_waddr), hd.addr);
        check_eq("rf_wdata", 32'(rf_wdata), hd.data);
        check_eq("fwd_hit1", 32'(fwd_hit1), 32'(h1));
        check_eq("fwd_hit2", 32'(fwd_hit2), 32'(h2));
        check_eq("fwd_data1", 32'(fwd_data1), d1);
        check_eq("fwd_data2", 32'(fwd_data2), d2);
        check_eq("retire_cnt", retire_cnt, m_rcnt);
        r      = rst;
        e_push = in_valid && e_ready && !rst;
        ne     = '{wen: in_wen, addr: 32'(in_waddr),
                   data: ext_model(in_sel, 32'(in_alu_data), 32'(in_mem_data),
                                   32'(in_mem_size), in_mem_signed)};
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_rcnt = 0;
        end else begin
            if (e_pop) begin
                void'(mq.pop_front());
                m_rcnt = m_rcnt + 1;
            end
            if (e_push) mq.push_back(ne);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        fwd_addr1 = '0;
        fwd_addr2 = '0;
        set_idle(0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();

        // ALU result to r3 appears on the write port one cycle after the push
        set_in(1, 1, 3, 0, 'h1234, 0, 0, 0, 0);
        tick();
        set_idle(0);
        #1;
        check_eq("alu_wen", 32'(rf_wen), 1);
        check_eq("alu_waddr", 32'(rf_waddr), 3);
        check_eq("alu_wdata", rf_wdata, 32'h1234);
        tick();
        check_eq("alu_retire", retire_cnt, 1);

        // signed and unsigned byte loads
        set_in(1, 1, 4, 1, 0, 'hF0, 0, 1, 0);
        tick();
        set_idle(0);
        #1 check_eq("lb_signed", rf_wdata, 32'hFFFF_FFF0);
        tick();
        set_in(1, 1, 4, 1, 0, 'hF0, 0, 0, 0);
        tick();
        set_idle(0);
        #1 check_eq("lb_unsigned", rf_wdata, 32'h0000_00F0);
        tick();

        // hold fills the queue, then drains in order
        set_in(1, 1, 6, 0, 'h61, 0, 0, 0, 1);
        tick();
        set_in(1, 1, 7, 0, 'h71, 0, 0, 0, 1);
        tick();
        set_in(1, 1, 8, 0, 'h81, 0, 0, 0, 1);
        #1 check_eq("full_ready", 32'(in_ready), 0);
        tick();
        set_idle(0);
        #1 check_eq("drain0", 32'(rf_waddr), 6);
        tick();
        #1 check_eq("drain1", 32'(rf_waddr), 7);
        tick();
        #1 check_eq("drain_empty", 32'(rf_wen), 0);
        tick();

        // youngest of two queued writes to r5 is forwarded
        set_in(1, 1, 5, 0, 'hA, 0, 0, 0, 1);
        tick();
        set_in(1, 1, 5, 0, 'hB, 0, 0, 0, 1);
        tick();
        set_idle(1);
        fwd_addr1 = AW'(5);
        fwd_addr2 = AW'(0);
        #1;
        check_eq("fwd_r5_hit", 32'(fwd_hit1), 32'(FWD));
        check_eq("fwd_r5_data", fwd_data1, FWD ? 32'hB : 32'h0);
        check_eq("fwd_r0_hit", 32'(fwd_hit2), 0);
        tick();
        set_idle(0);
        tick();
        tick();

        // write to r0 retires without a register-file write
        set_in(1, 1, 0, 0, 'h99, 0, 0, 0, 0);
        tick();
        set_idle(0);
        #1 check_eq("r0_wen", 32'(rf_wen), 0);
        tick();
        check_eq("r0_retire", retire_cnt, 8);

        // reset with two queued entries discards them
        set_in(1, 1, 9, 0, 'h91, 0, 0, 0, 1);
        tick();
        set_in(1, 1, 10, 0, 'hA1, 0, 0, 0, 1);
        tick();
        set_in(1, 1, 11, 0, 'hB1, 0, 0, 0, 0);
        rst = 1'b1;
        #1 check_eq("rst_no_wen", 32'(rf_wen), 0);
        tick();
        rst = 1'b0;
        set_idle(0);
        #1;
        check_eq("rst_retire", retire_cnt, 0);
        check_eq("rst_ready", 32'(in_ready), 1);
        check_eq("rst_wdata", rf_wdata, 0);
        tick();

        // retire counter wraps
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1 release dut.retire_cnt;
        m_rcnt = 32'hFFFF_FFFF;
        set_in(1, 1, 12, 0, 'hC1, 0, 0, 0, 0);
        tick();
        set_idle(0);
        tick();
        check_eq("retire_wrap", retire_cnt, 0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                   $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3);
            rst       = ($urandom_range(0, 49) == 0);
            fwd_addr1 = AW'($urandom_range(0, 7));
            fwd_addr2 = AW'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DEPTH, default 2, number of write-back queue entries (legal 1..4).
REQ-002 Widths `ASIZE, `DSIZE and `NREG SHALL come from define.v; no local width literals.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  upstream result valid.
REQ-006 in_ready  out  1  stage accepts this cycle; transfer when in_valid & in_ready.
REQ-007 in_wen  in  1  instruction writes a register.
REQ-008 in_waddr  in  `ASIZE  destination register.
REQ-009 in_sel  in  1  0 = ALU result, 1 = load data.
REQ-010 in_alu_data, in_mem_data  in  `DSIZE each  candidate results.
REQ-011 in_mem_size  in  2  00 byte, 01 half, 10/11 word.
REQ-012 in_mem_signed  in  1  sign-extend loads when 1, zero-extend when 0.
REQ-013 hold  in  1  freeze draining of the queue (debug/stall).
REQ-014 rf_wen, rf_waddr, rf_wdata  out  1/`ASIZE/`DSIZE  register-file write port.
REQ-015 fwd_addr1, fwd_addr2  in  `ASIZE  decode read addresses.
REQ-016 fwd_hit1/2  out  1 each, and fwd_data1/2  out  `DSIZE each  bypass results.
REQ-017 retire_cnt  out  32  count of drained entries.

Function
REQ-018 Internal FIFO of DEPTH entries {wen, waddr, data}; data is stored already selected and extended.
REQ-019 Push: in_valid & in_ready; byte/half load data is extended from bits [7:0]/[15:0] per in_mem_signed; word and ALU data are stored unchanged.
REQ-020 Pop: queue non-empty & !hold, evaluated every cycle.
REQ-021 in_ready = !full | pop; push and pop in the same cycle when full SHALL keep the count unchanged.
REQ-022 rf_wen = pop & head.wen & (head.waddr != 0); rf_waddr/rf_wdata = head fields, driven combinationally.
REQ-023 rf_waddr and rf_wdata SHALL be 0 whenever the queue is empty.
REQ-024 Latency: entry pushed at edge N drives rf_* in cycle N+1 if the queue was empty and hold=0; the register file captures it at edge N+2.
REQ-025 Ordering is strict FIFO; entries are never dropped or reordered.
REQ-026 hold=1 stops pops; pushes continue until full, then in_ready=0.
REQ-027 retire_cnt increments by 1 per pop, including wen=0 entries, and wraps from 0xFFFFFFFF to 0.
REQ-028 Register 0 is never written; a write to r0 is still retired.

Reset
REQ-029 rst at posedge empties the queue and clears retire_cnt, so that in the following cycle rf_wen=0, rf_waddr=0, rf_wdata=0, fwd_hit*=0, fwd_data*=0 and in_ready=1.
REQ-030 rst mid-operation discards queued entries without writing them; in_valid is ignored while rst=1.

Configuration
REQ-031 Macro WB_FWD_EN defined: fwd_hitK=1 when any queued entry has wen=1, waddr==fwd_addrK and waddr!=0; fwd_dataK = data of the youngest such entry; otherwise fwd_dataK=0.
REQ-032 Forwarding SHALL include the head entry popped this cycle and exclude the entry being pushed this cycle.
REQ-033 Macro WB_FWD_EN undefined: no comparators are built; fwd_hit1/2 and fwd_data1/2 are tied to 0.

Structure
REQ-034 A shared package (define.v or a new wb_pkg) SHALL hold the memory-size encodings (MSZ_BYTE/MSZ_HALF/MSZ_WORD) and the queue-entry field layout.
REQ-035 Load extension SHALL be a combinational sub-module, load_ext, instantiated once.
REQ-036 The queue is implemented inline with a pointer/count; no separate FIFO module.

Verification
REQ-037 Push ALU 0x1234 to r3, hold=0 -> cycle N+1 rf_wen=1, rf_waddr=3, rf_wdata=0x1234; retire_cnt=1.
REQ-038 Load mem_data 0x000000F0, size 00, signed=1 -> rf_wdata 0xFFFFFFF0; with signed=0 -> 0x000000F0.
REQ-039 hold=1, push 3 entries (DEPTH=2) -> in_ready=0 after two pushes; release hold -> entries drain in order, one per cycle.
REQ-040 Queue r5=0xA then r5=0xB, hold=1, fwd_addr1=5 -> fwd_hit1=1, fwd_data1=0xB; fwd_addr2=0 -> fwd_hit2=0 (WB_FWD_EN defined).
REQ-041 Push wen=1 to r0 -> rf_wen=0, retire_cnt increments; rst with 2 queued entries -> no rf_wen pulse, retire_cnt=0.
REQ-042 Preset retire_cnt to 0xFFFFFFFF via force, pop one entry -> retire_cnt=0.
